pipo_load_arbiter: RTL and testbench
====================================

Name: pipo_load_arbiter

Overview:
- Round-robin arbiter that shares one parallel-in/parallel-out data register among N_REQ requesters.
- Each requester presents a DATA_W-bit word and a request. The winner's word is loaded into the shared register in one cycle.
- The loaded value is held for a guaranteed HOLD_CYC cycles before the register can be reloaded.
- Sits between producer blocks and the shared PIPO-style storage, sequencing all loads into it.

Parameters:
- N_REQ, 4, number of requesters; range 2..8.
- DATA_W, 3, width of each requester word and of dout.
- HOLD_CYC, 2, number of cycles the register is held busy after a load; range 1..255.
- OWN_W, $clog2(N_REQ), width of the owner index; derived, not overridden.

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset: reset==0 at a rising edge resets the block.
- req  input  N_REQ  per-requester load request, level.
- datain  input  N_REQ*DATA_W  packed requester words; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  N_REQ  one-hot grant, one-cycle pulse.
- dout  output  DATA_W  shared register contents.
- dout_valid  output  1  one-cycle pulse in the cycle dout takes a new value.
- owner  output  OWN_W  index of the requester whose word is in dout.
- busy  output  1  high while in HOLD.

Behaviour:
- Reset values (reset==0 at an edge): gnt=0, dout=0, dout_valid=0, owner=0, busy=0, state=IDLE, hold counter=0, RR pointer=N_REQ-1. With this pointer, requester 0 has first priority after reset.
- States:
  - IDLE: arbitrate.
  - HOLD: count down, ignore req.
- IDLE, no req bit set: stay in IDLE; outputs hold; gnt=0, dout_valid=0.
- IDLE, any req bit set, at the edge:
  - Winner w = first set req bit searching upward from pointer+1, wrapping modulo N_REQ.
  - gnt <= onehot(w), dout <= datain lane w, owner <= w, dout_valid <= 1, pointer <= w, counter <= HOLD_CYC-1, state <= HOLD.
- Latency: req sampled in cycle t gives gnt, dout and dout_valid in cycle t+1.
- HOLD:
  - gnt=0 and dout_valid=0 from the second HOLD cycle onward.
  - busy=1 in every HOLD cycle.
  - Counter decrements each cycle. At an edge with counter==0, state <= IDLE.
  - HOLD therefore lasts exactly HOLD_CYC cycles, including the gnt cycle.
- Minimum spacing between gnt pulses is HOLD_CYC+1 cycles.
- Requester protocol:
  - Hold req and its datain lane stable until gnt is seen.
  - Drop req at the edge ending the gnt cycle.
  - req may still be high during the gnt cycle; this is harmless because the block is in HOLD.
- dout and owner retain their last loaded values indefinitely between loads.
- Pointer wrap: pointer=N_REQ-1 makes the search start at requester 0.
- Simultaneous requests: exactly one grant per arbitration; gnt is always one-hot or zero.
- Reset mid-HOLD: the block returns to IDLE immediately and all outputs take their reset values. The pending hold is discarded.
- A req bit that drops before it is granted is simply not considered; there is no latching of requests.

Optional Feature:
- Macro: PIPO_ARB_HIPRI_REQ0_EN.
- Defined: in IDLE, req[0]=1 always wins regardless of the pointer. The pointer is still updated to the winner, and the remaining requesters keep round-robin order among themselves.
- Undefined: pure round-robin as above, with no special requester.

Decomposition:
- Shared package pipo_arb_pkg:
  - State enum {IDLE, HOLD}.
  - Default constants for N_REQ, DATA_W and HOLD_CYC.
  - Counter width constant HOLD_W = $clog2(HOLD_CYC+1).
- Sub-module rr_picker: purely combinational.
  - Inputs: req and pointer.
  - Outputs: winner index and any-request flag.
  - Also instantiated by other arbiters in the codebase.
- FSM, counter and datapath register stay in pipo_load_arbiter.

Test Plan (N_REQ=4, DATA_W=3, HOLD_CYC=2):
- Reset: reset=0 for 2 cycles with req=4'b1111 -> gnt=0000, dout=000, owner=0, busy=0, dout_valid=0.
- Single load: IDLE, req=0100, lane2=101 in cycle 0 -> cycle 1: gnt=0100, dout=101, owner=2, dout_valid=1, busy=1. Cycle 2: busy=1, gnt=0, dout=101. Cycle 3: busy=0.
- Full contention: all four requesters re-raise req the cycle after their gnt -> grant order 0,1,2,3,0, with gnt pulses exactly 3 cycles apart and dout tracking each lane.
- Wrap: after a grant to 3, req=1001 -> grant 0. Then req=1001 again -> grant 3.
- Reset mid-HOLD: reset=0 in the gnt cycle -> next cycle busy=0, dout=000. Then req=0110 -> grant 1.
- Priority feature: last grant 0, req=1011 -> grant 1 when PIPO_ARB_HIPRI_REQ0_EN is undefined, grant 0 when it is defined.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// ----------------------------------------------------------------------------
// pipo_arb_pkg
//   Shared definitions for the PIPO load arbiter and its round-robin picker.
//   Holds the arbiter state encoding, the default parameter values and a
//   helper that sizes the hold counter for a given hold length.
// ----------------------------------------------------------------------------
package pipo_arb_pkg;

    // Arbiter states: IDLE arbitrates, HOLD keeps the register busy.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Default configuration.
    localparam int N_REQ_DEF    = 4;
    localparam int DATA_W_DEF   = 3;
    localparam int HOLD_CYC_DEF = 2;

    // Width needed to hold the values 0..hold_cyc.
    function automatic int hold_w(input int hold_cyc);
        return $clog2(hold_cyc + 1);
    endfunction

    // Hold counter width for the default hold length.
    localparam int HOLD_W = hold_w(HOLD_CYC_DEF);

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Purely combinational round-robin picker. Searches req upward starting at
//   ptr+1, wrapping modulo N_REQ, and reports the first set bit.
//
// Ports:
//   req      in   N_REQ   request vector
//   ptr      in   OWN_W   index of the last winner (search starts after it)
//   winner   out  OWN_W   index of the chosen requester (0 when none)
//   any_req  out  1       at least one request bit is set
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int OWN_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] ptr,
    output logic [OWN_W-1:0] winner,
    output logic             any_req
);

    logic found;
    int   idx;

    // NOTE: every variable written in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        any_req = |req;
        // Offsets 1..N_REQ cover every requester once, ending on ptr itself,
        // so the last winner has the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                winner = OWN_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// ----------------------------------------------------------------------------
// pipo_load_arbiter
//   Round-robin arbiter in front of one shared parallel-in/parallel-out data
//   register. In IDLE the winning requester's word is loaded in one cycle;
//   the block then sits in HOLD for HOLD_CYC cycles (the grant cycle counts)
//   before it arbitrates again, so grants are at least HOLD_CYC+1 apart.
//
//   Optional feature, macro PIPO_ARB_HIPRI_REQ0_EN: when defined, req[0]
//   always wins in IDLE; the pointer still moves to the winner, so the other
//   requesters keep their round-robin order. Undefined: pure round-robin.
//
// Ports:
//   clock       in   1             rising-edge clock
//   reset       in   1             synchronous active-low reset
//   req         in   N_REQ         per-requester load request (level)
//   datain      in   N_REQ*DATA_W  packed words, lane i at [i*DATA_W +: DATA_W]
//   gnt         out  N_REQ         one-hot grant, one-cycle pulse
//   dout        out  DATA_W        shared register contents
//   dout_valid  out  1             pulse in the cycle dout takes a new value
//   owner       out  OWN_W         requester whose word is in dout
//   busy        out  1             high in every HOLD cycle
// ----------------------------------------------------------------------------
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter  int N_REQ    = N_REQ_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int HOLD_CYC = HOLD_CYC_DEF,
    localparam int OWN_W    = $clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] datain,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    output logic [OWN_W-1:0]        owner,
    output logic                    busy
);

    localparam int CNT_W = hold_w(HOLD_CYC);

    // Registered state and its next-state values.
    arb_state_t        state,   state_n;
    logic [CNT_W-1:0]  cnt,     cnt_n;
    logic [OWN_W-1:0]  ptr,     ptr_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [DATA_W-1:0] dout_n;
    logic              dv_n;
    logic [OWN_W-1:0]  owner_n;

    // Arbitration result.
    logic [OWN_W-1:0]  rr_winner;
    logic              any_req;
    logic [OWN_W-1:0]  win;

    rr_picker #(
        .N_REQ   (N_REQ)
    ) u_picker (
        .req     (req),
        .ptr     (ptr),
        .winner  (rr_winner),
        .any_req (any_req)
    );

`ifdef PIPO_ARB_HIPRI_REQ0_EN
    // Requester 0 pre-empts the rotation whenever it asks.
    assign win = req[0] ? '0 : rr_winner;
`else
    assign win = rr_winner;
`endif

    assign busy = (state == HOLD);

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        gnt_n   = '0;
        dv_n    = 1'b0;
        dout_n  = dout;
        owner_n = owner;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_n[win] = 1'b1;
                    dout_n     = datain[win*DATA_W +: DATA_W];
                    owner_n    = win;
                    dv_n       = 1'b1;
                    ptr_n      = win;
                    // The grant cycle is the first HOLD cycle, so count from
                    // HOLD_CYC-1 down to 0.
                    cnt_n      = CNT_W'(HOLD_CYC - 1);
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                // req is ignored here; a requester still asserting req in the
                // grant cycle cannot cause a second load.
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            // Pointing at the last requester gives requester 0 first priority.
            ptr        <= OWN_W'(N_REQ - 1);
            gnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            owner      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            gnt        <= gnt_n;
            dout       <= dout_n;
            dout_valid <= dv_n;
            owner      <= owner_n;
        end
    end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pipo_load_arbiter
//   Directed bench for pipo_load_arbiter with N_REQ=4, DATA_W=3, HOLD_CYC=2.
//   Expected values are hand-derived; outputs are sampled 1 time unit after
//   each rising edge, inputs change at the same point.
// ----------------------------------------------------------------------------
module tb_pipo_load_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] datain;
    logic [3:0]  gnt;
    logic [2:0]  dout;
    logic        dout_valid;
    logic [1:0]  owner;
    logic        busy;

    int vectors = 0;
    int fails   = 0;

    pipo_load_arbiter #(
        .N_REQ    (4),
        .DATA_W   (3),
        .HOLD_CYC (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .datain     (datain),
        .gnt        (gnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .owner      (owner),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : stimulus
        int cyc;
        int last;
        int n;
        int lane;
        logic [3:0] exp_gnt;

        reset  = 1'b0;
        req    = 4'b1111;
        datain = 12'hfff;

        // Reset held for two edges with every request raised.
        tick();
        tick();
        chk("rst_gnt",   32'(gnt),        32'h0);
        chk("rst_dout",  32'(dout),       32'h0);
        chk("rst_owner", 32'(owner),      32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_dv",    32'(dout_valid), 32'h0);

        // Single load of lane 2.
        reset  = 1'b1;
        req    = 4'b0000;
        datain = 12'b000_101_000_000;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);
        req = 4'b0100;
        tick();
        chk("ld_gnt",   32'(gnt),        32'h4);
        chk("ld_dout",  32'(dout),       32'h5);
        chk("ld_owner", 32'(owner),      32'h2);
        chk("ld_dv",    32'(dout_valid), 32'h1);
        chk("ld_busy",  32'(busy),       32'h1);
        req = 4'b0000;
        tick();
        chk("h2_busy", 32'(busy),       32'h1);
        chk("h2_gnt",  32'(gnt),        32'h0);
        chk("h2_dv",   32'(dout_valid), 32'h0);
        chk("h2_dout", 32'(dout),       32'h5);
        tick();
        chk("end_busy",  32'(busy),  32'h0);
        chk("end_dout",  32'(dout),  32'h5);
        chk("end_owner", 32'(owner), 32'h2);
        tick();
        tick();
        chk("keep_dout", 32'(dout),       32'h5);
        chk("keep_dv",   32'(dout_valid), 32'h0);

        // Full contention from a fresh reset: lane i carries i+1.
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        req    = 4'b1111;
        datain = 12'b100_011_010_001;
        cyc    = 0;
        last   = 0;
        for (int g = 0; g < 5; g++) begin
            lane = g % 4;
            n    = 0;
            do begin
                tick();
                cyc++;
                n++;
            end while (gnt == 4'b0000 && n < 10);
            exp_gnt = 4'b0001 << lane;
            chk($sformatf("cont%0d_gnt", g),   32'(gnt),   32'(exp_gnt));
            chk($sformatf("cont%0d_dout", g),  32'(dout),  32'(lane + 1));
            chk($sformatf("cont%0d_owner", g), 32'(owner), 32'(lane));
            if (g > 0) begin
                chk($sformatf("cont%0d_gap", g), 32'(cyc - last), 32'd3);
            end
            last = cyc;
            // Drop at the edge ending the grant cycle, re-raise right after.
            req[lane] = 1'b0;
            tick();
            cyc++;
            req[lane] = 1'b1;
        end
        req = 4'b0000;
        tick();

        // Wrap: grant 3, then 1001 must go to 0, and 1001 again to 3.
        req = 4'b1000;
        tick();
        chk("wrap_g3", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        tick();
        req = 4'b1001;
        tick();
        chk("wrap_g0",    32'(gnt),   32'h1);
        chk("wrap_own0",  32'(owner), 32'h0);
        chk("wrap_dout0", 32'(dout),  32'h1);
        req = 4'b0000;
        tick();
        tick();
        req = 4'b1001;
        tick();
`ifdef PIPO_ARB_HIPRI_REQ0_EN
        chk("wrap_again", 32'(gnt), 32'h1);
`else
        chk("wrap_again", 32'(gnt), 32'h8);
`endif
        req = 4'b0000;
        tick();
        tick();

        // Reset in the grant cycle discards the hold.
        req = 4'b0010;
        tick();
        chk("mid_gnt", 32'(gnt), 32'h2);
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        chk("mid_busy",  32'(busy),  32'h0);
        chk("mid_dout",  32'(dout),  32'h0);
        chk("mid_owner", 32'(owner), 32'h0);
        chk("mid_gnt0",  32'(gnt),   32'h0);
        reset = 1'b1;
        req   = 4'b0110;
        tick();
        chk("post_gnt",  32'(gnt),  32'h2);
        chk("post_dout", 32'(dout), 32'h2);
        req = 4'b0000;
        tick();
        tick();

        // Priority: after a grant to 0, 1011 goes to 1 unless req0 pre-empts.
        req = 4'b0001;
        tick();
        chk("pri_g0", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        req = 4'b1011;
        tick();
`ifdef PIPO_ARB_HIPRI_REQ0_EN
        chk("pri_gnt",   32'(gnt),   32'h1);
        chk("pri_owner", 32'(owner), 32'h0);
`else
        chk("pri_gnt",   32'(gnt),   32'h2);
        chk("pri_owner", 32'(owner), 32'h1);
`endif
        req = 4'b0000;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
